conv_win_fetch: RTL and testbench

// Datapath fetch/write stage driven by the CONV controller's one-hot cmd_flags. Keeps the current output-pixel

---
 rtl/conv_win_fetch.sv | 144 ++++++++++++++
 tb/tb_conv_win_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_win_fetch.sv
// rtl/conv_win_fetch.sv - CONV 3x3 window fetch with zero padding and layer-0 result write
// Optional feature macro: CONV_SKIP_PAD_EN (READ issues only non-padded taps).
module conv_win_fetch #(
  parameter int IMG_W  = 64,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_set,
  input  logic                cmd_read,
  input  logic                cmd_write,
  input  logic                dp_cnt_rst,
  input  logic [DATA_W-1:0]   idata,
  input  logic [DATA_W-1:0]   conv_result,
  output logic [ADDR_W-1:0]   iaddr,
  output logic                set_done,
  output logic                read_done,
  output logic [9*DATA_W-1:0] win_flat,
  output logic                cwr,
  output logic [ADDR_W-1:0]   caddr_wr,
  output logic [DATA_W-1:0]   cdata_wr,
  output logic                write_nyet_done,
  output logic                write_all_done
);

  localparam int            PW      = ADDR_W / 2;
  localparam logic [PW-1:0] POS_MAX = PW'(IMG_W - 1);
  localparam logic [PW:0]   ONE     = 1;

  logic [PW-1:0]     row;
  logic [PW-1:0]     col;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] win [9];

  logic              do_write;
  logic              do_read;
  logic              do_set;
  logic              at_last;
  logic [PW:0]       rx [3];
  logic [PW:0]       cx [3];
  logic [8:0]        pad_vec;
  logic [ADDR_W-1:0] tap_addr [9];
  logic [3:0]        issue_tap;

  assign do_write = cmd_write;
  assign do_read  = cmd_read & ~cmd_write;
  assign do_set   = cmd_set & ~cmd_read & ~cmd_write;

  // One extra bit per coordinate: -1 and IMG_W both land with the top bit set.
  assign rx[0] = {1'b0, row} - ONE;
  assign rx[1] = {1'b0, row};
  assign rx[2] = {1'b0, row} + ONE;
  assign cx[0] = {1'b0, col} - ONE;
  assign cx[1] = {1'b0, col};
  assign cx[2] = {1'b0, col} + ONE;

  for (genvar k = 0; k < 9; k++) begin : g_tap
    assign pad_vec[k]                   = rx[k/3][PW] | cx[k%3][PW];
    assign tap_addr[k]                  = {rx[k/3][PW-1:0], cx[k%3][PW-1:0]};
    assign win_flat[k*DATA_W +: DATA_W] = win[k];
  end

  assign at_last         = (row == POS_MAX) && (col == POS_MAX);
  assign cwr             = do_write;
  assign caddr_wr        = do_write ? {row, col} : '0;
  assign cdata_wr        = do_write ? conv_result : '0;
  assign write_all_done  = do_write & at_last;
  assign write_nyet_done = do_write & ~at_last;
  assign set_done        = do_set;
  assign read_done       = do_read && (cnt == 4'd9);

`ifdef CONV_SKIP_PAD_EN
  logic [3:0] nxt_tap;
  logic [3:0] prev_tap;
  logic       prev_vld;

  // First non-padded tap at or after cnt, and the one after that (9 = none).
  always_comb begin
    issue_tap = 4'd9;
    nxt_tap   = 4'd9;
    for (int k = 8; k >= 0; k--) begin
      if (!pad_vec[k] && (4'(k) >= cnt)) issue_tap = 4'(k);
    end
    for (int k = 8; k >= 0; k--) begin
      if (!pad_vec[k] && (4'(k) > issue_tap)) nxt_tap = 4'(k);
    end
  end
`else
  assign issue_tap = cnt;
`endif

  always_comb begin
    iaddr = '0;
    for (int k = 0; k < 9; k++) begin
      if (do_read && (issue_tap == 4'(k)) && !pad_vec[k]) iaddr = tap_addr[k];
    end
  end

  always_ff @(posedge clk) begin
`ifdef CONV_SKIP_PAD_EN
    prev_vld <= 1'b0;
`endif
    if (reset) begin
      row <= '0;
      col <= '0;
      cnt <= '0;
      for (int k = 0; k < 9; k++) win[k] <= '0;
`ifdef CONV_SKIP_PAD_EN
      prev_tap <= '0;
`endif
    end else if (do_write) begin
      cnt <= '0;
      col <= col + 1'b1;
      if (col == POS_MAX) row <= row + 1'b1;
    end else if (do_read) begin
`ifdef CONV_SKIP_PAD_EN
      if (cnt == 4'd0) begin
        for (int k = 0; k < 9; k++) if (pad_vec[k]) win[k] <= '0;
      end
      // Data for the tap issued last cycle arrives now.
      if (prev_vld) begin
        for (int k = 0; k < 9; k++) if (prev_tap == 4'(k)) win[k] <= idata;
      end
      prev_vld <= (issue_tap != 4'd9);
      prev_tap <= issue_tap;
      if (dp_cnt_rst)          cnt <= '0;
      else if (cnt < 4'd9)     cnt <= nxt_tap;
`else
      for (int k = 0; k < 9; k++) begin
        if (cnt == 4'(k + 1)) win[k] <= pad_vec[k] ? '0 : idata;
      end
      if (dp_cnt_rst)          cnt <= '0;
      else if (cnt < 4'd9)     cnt <= cnt + 4'd1;
`endif
    end else if (do_set) begin
      cnt <= '0;
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (dp_cnt_rst) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_conv_win_fetch.sv
// tb/tb_conv_win_fetch.sv - directed self-checking bench for conv_win_fetch
module tb_conv_win_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_set;
  logic         cmd_read;
  logic         cmd_write;
  logic         dp_cnt_rst;
  logic [19:0]  idata;
  logic [19:0]  conv_result;
  logic [11:0]  iaddr;
  logic         set_done;
  logic         read_done;
  logic [179:0] win_flat;
  logic         cwr;
  logic [11:0]  caddr_wr;
  logic [19:0]  cdata_wr;
  logic         write_nyet_done;
  logic         write_all_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_tap [9];

  conv_win_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_set         (cmd_set),
    .cmd_read        (cmd_read),
    .cmd_write       (cmd_write),
    .dp_cnt_rst      (dp_cnt_rst),
    .idata           (idata),
    .conv_result     (conv_result),
    .iaddr           (iaddr),
    .set_done        (set_done),
    .read_done       (read_done),
    .win_flat        (win_flat),
    .cwr             (cwr),
    .caddr_wr        (caddr_wr),
    .cdata_wr        (cdata_wr),
    .write_nyet_done (write_nyet_done),
    .write_all_done  (write_all_done)
  );

  always #5 clk = ~clk;

  // Image memory with mem[a] = a and one cycle of read latency.
  always @(posedge clk) idata <= {8'b0, iaddr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_read(input string tag);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      cmd_read = 1'b1;
      #1;
      if (cyc <= 9) check($sformatf("%s iaddr%0d", tag, cyc - 1), 32'(iaddr), exp_tap[cyc-1]);
      check($sformatf("%s read_done c%0d", tag, cyc), 32'(read_done), 32'(cyc == 10));
      @(negedge clk);
    end
    cmd_read = 1'b0;
    #1;
    for (int k = 0; k < 9; k++)
      check($sformatf("%s win%0d", tag, k), 32'(win_flat[k*20 +: 20]), exp_tap[k]);
    @(negedge clk);
  endtask

  task automatic pulse_writes(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_write = 1'b1;
      @(negedge clk);
    end
    cmd_write = 1'b0;
  endtask

  initial begin
    int n_all, a_all, e_addr, e_rd, e_set, e_nyet;
    reset = 1'b1; cmd_set = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0;
    dp_cnt_rst = 1'b0; conv_result = 20'hABCDE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst iaddr", 32'(iaddr), 0);
    check("rst cwr", 32'(cwr), 0);
    check("rst cdata_wr", 32'(cdata_wr), 0);
    check("rst set_done", 32'(set_done), 0);
    check("rst read_done", 32'(read_done), 0);
    check("rst win_nonzero", 32'(win_flat != '0), 0);
    @(negedge clk);

    // T1: single SET cycle
    cmd_set = 1'b1;
    #1;
    check("T1 set_done", 32'(set_done), 1);
    check("T1 iaddr", 32'(iaddr), 0);
    check("T1 cwr", 32'(cwr), 0);
    check("T1 win_nonzero", 32'(win_flat != '0), 0);
    @(negedge clk);
    cmd_set = 1'b0;
    #1;
    check("T1 set_done low", 32'(set_done), 0);
    @(negedge clk);

    // T2: corner window at (0,0)
    exp_tap = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    run_read("T2");

    // T4: write at (0,63), then position must be (1,0)
    pulse_writes(63);
    cmd_write = 1'b1; conv_result = 20'h12345;
    #1;
    check("T4 cwr", 32'(cwr), 1);
    check("T4 caddr_wr", 32'(caddr_wr), 63);
    check("T4 cdata_wr", 32'(cdata_wr), 32'h12345);
    check("T4 nyet", 32'(write_nyet_done), 1);
    check("T4 all_done", 32'(write_all_done), 0);
    @(negedge clk);
    #1;
    check("T4 next pos", 32'(caddr_wr), 64);
    @(negedge clk);
    pulse_writes(595);

    // T3: interior window at (10,20)
    exp_tap = '{595, 596, 597, 659, 660, 661, 723, 724, 725};
    run_read("T3");

    // cnt holds at 9; dp_cnt_rst restarts and overrides the increment
    cmd_read = 1'b1; dp_cnt_rst = 1'b1;
    #1;
    check("hold read_done", 32'(read_done), 1);
    check("hold iaddr", 32'(iaddr), 0);
    @(negedge clk);
    dp_cnt_rst = 1'b0;
    #1;
    check("rst0 iaddr", 32'(iaddr), 595);
    check("rst0 read_done", 32'(read_done), 0);
    @(negedge clk);
    dp_cnt_rst = 1'b1;
    #1;
    check("rst1 iaddr", 32'(iaddr), 596);
    @(negedge clk);
    dp_cnt_rst = 1'b0;
    #1;
    check("override iaddr", 32'(iaddr), 595);
    @(negedge clk);

    // Priority: read beats set, write beats both
    cmd_set = 1'b1;
    #1;
    check("prio rs set_done", 32'(set_done), 0);
    check("prio rs iaddr", 32'(iaddr), 596);
    @(negedge clk);
    cmd_write = 1'b1; conv_result = 20'h0BEEF;
    #1;
    check("prio all cwr", 32'(cwr), 1);
    check("prio all caddr", 32'(caddr_wr), 660);
    check("prio all cdata", 32'(cdata_wr), 32'h0BEEF);
    check("prio all set_done", 32'(set_done), 0);
    check("prio all read_done", 32'(read_done), 0);
    check("prio all iaddr", 32'(iaddr), 0);
    @(negedge clk);
    cmd_set = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0;

    // T6: reset in READ cycle 4 at (10,21)
    cmd_read = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; cmd_read = 1'b0;
    #1;
    check("T6 win_nonzero", 32'(win_flat != '0), 0);
    check("T6 read_done", 32'(read_done), 0);
    @(negedge clk);
    exp_tap = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    run_read("T6");
    cmd_write = 1'b1;
    #1;
    check("T6 pos", 32'(caddr_wr), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("T6 no partial write", 32'(caddr_wr), 0);
    @(negedge clk);
    cmd_write = 1'b0;

    // T5: full image of SET/READ/WRITE loops
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_all = 0; a_all = -1; e_addr = 0; e_rd = 0; e_set = 0; e_nyet = 0;
    for (int p = 0; p < 4096; p++) begin
      cmd_set = 1'b1;
      #1;
      if (set_done !== 1'b1) e_set++;
      @(negedge clk);
      cmd_set = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        cmd_read = 1'b1;
        #1;
        if (read_done !== (c == 10)) e_rd++;
        @(negedge clk);
      end
      cmd_read = 1'b0; cmd_write = 1'b1; conv_result = 20'(p);
      #1;
      if (caddr_wr !== p[11:0]) e_addr++;
      if (write_all_done === 1'b1) begin
        n_all++;
        a_all = int'(caddr_wr);
      end
      if (write_nyet_done === write_all_done) e_nyet++;
      @(negedge clk);
      cmd_write = 1'b0;
    end
    check("T5 all_done count", n_all, 1);
    check("T5 all_done addr", a_all, 4095);
    check("T5 addr errors", e_addr, 0);
    check("T5 read_done errors", e_rd, 0);
    check("T5 set_done errors", e_set, 0);
    check("T5 nyet errors", e_nyet, 0);
    cmd_write = 1'b1;
    #1;
    check("T5 wrap pos", 32'(caddr_wr), 0);
    @(negedge clk);
    cmd_write = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
